// File: rtl/array_multiplier_pipelined.sv
// ----------------------------------------------------------------------------
// array_multiplier_pipelined
//
// Pipelined WIDTH x WIDTH array multiplier. Each pipeline stage adds
// ROWS_PER_STAGE partial-product rows to a running 2*WIDTH-bit sum. The stage
// register also carries the operands forward so that later stages can form
// their own rows. One product can enter and one can leave every cycle.
//
// Every operand pair carries its own signed/unsigned flag, so signed and
// unsigned products can be mixed back to back.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   in_valid     operands on in_a/in_b/in_signed are valid
//   in_ready     block accepts operands this cycle
//   in_a         multiplicand, WIDTH bits
//   in_b         multiplier, WIDTH bits
//   in_signed    1 = both operands two's complement, 0 = both unsigned
//   out_valid    out_product holds a valid result
//   out_ready    consumer accepts the product
//   out_product  full 2*WIDTH-bit product, straight from the last stage register
//
// Parameters
//   WIDTH           operand width, 2..32
//   ROWS_PER_STAGE  partial-product rows per pipeline stage, 1..WIDTH
//   Pipeline depth LAT = ceil(WIDTH / ROWS_PER_STAGE) register stages.
// ----------------------------------------------------------------------------
module array_multiplier_pipelined #(
    parameter int WIDTH          = 8,
    parameter int ROWS_PER_STAGE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product
);

    localparam int LAT = (WIDTH + ROWS_PER_STAGE - 1) / ROWS_PER_STAGE;
    localparam int PW  = 2 * WIDTH;

    // Adds partial-product rows lo..hi-1 to base. The loop runs over every row
    // so its bounds stay constant; rows outside the window are skipped.
    // In signed mode a is sign-extended and the row for the multiplier's sign
    // bit has negative weight, so it is subtracted.
    function automatic logic [PW-1:0] add_rows(
        input logic [PW-1:0]    base,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             sgn,
        input int               lo,
        input int               hi
    );
        logic [PW-1:0] ext_a;
        logic [PW-1:0] row;
        logic [PW-1:0] acc;
        ext_a = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        acc   = base;
        for (int i = 0; i < WIDTH; i++) begin
            row = b[i] ? (ext_a << i) : '0;
            if (i >= lo && i < hi) begin
                if (sgn && i == WIDTH - 1) begin
                    acc = acc - row;
                end else begin
                    acc = acc + row;
                end
            end
        end
        return acc;
    endfunction

    logic                adv;

    // Stage registers: valid bit and running partial sum for every stage.
    logic [LAT-1:0]      valid_q;
    logic [PW-1:0]       sum_q [LAT];
    logic [PW-1:0]       sum_d [LAT];

    // Inputs seen by each stage: stage 0 sees the ports, stage k sees the
    // registers of stage k-1.
    logic [LAT-1:0]      st_valid;
    logic [LAT-1:0]      st_sgn;
    logic [WIDTH-1:0]    st_a   [LAT];
    logic [WIDTH-1:0]    st_b   [LAT];
    logic [PW-1:0]       st_sum [LAT];

    // The whole pipeline moves together; a held output freezes every stage,
    // bubbles included, so nothing is dropped or duplicated.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !rst;

    assign out_valid   = valid_q[LAT-1];
    assign out_product = sum_q[LAT-1];

    // The last stage has already added every row, so only the first LAT-1
    // stages need to carry the operands and the mode flag.
    generate
        if (LAT > 1) begin : g_ops
            logic [WIDTH-1:0] a_q [LAT-1];
            logic [WIDTH-1:0] b_q [LAT-1];
            logic [LAT-2:0]   sgn_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < LAT - 1; k++) begin
                        a_q[k] <= '0;
                        b_q[k] <= '0;
                    end
                    sgn_q <= '0;
                end else if (adv) begin
                    for (int k = 0; k < LAT - 1; k++) begin
                        // Operands only move with a valid token; bubbles leave them as they are.
                        if (st_valid[k]) begin
                            a_q[k]   <= st_a[k];
                            b_q[k]   <= st_b[k];
                            sgn_q[k] <= st_sgn[k];
                        end
                    end
                end
            end

            always_comb begin
                st_valid[0] = in_valid;
                st_sgn[0]   = in_signed;
                st_a[0]     = in_a;
                st_b[0]     = in_b;
                st_sum[0]   = '0;
                for (int k = 1; k < LAT; k++) begin
                    st_valid[k] = valid_q[k-1];
                    st_sgn[k]   = sgn_q[k-1];
                    st_a[k]     = a_q[k-1];
                    st_b[k]     = b_q[k-1];
                    st_sum[k]   = sum_q[k-1];
                end
            end
        end else begin : g_single
            always_comb begin
                st_valid[0] = in_valid;
                st_sgn[0]   = in_signed;
                st_a[0]     = in_a;
                st_b[0]     = in_b;
                st_sum[0]   = '0;
            end
        end
    endgenerate

    // Stage k adds rows k*ROWS_PER_STAGE up to the next stage boundary. The
    // last stage may have fewer rows when the width does not divide evenly.
    always_comb begin
        for (int k = 0; k < LAT; k++) begin
            sum_d[k] = add_rows(st_sum[k], st_a[k], st_b[k], st_sgn[k],
                                k * ROWS_PER_STAGE,
                                (((k + 1) * ROWS_PER_STAGE) > WIDTH) ? WIDTH
                                                                     : ((k + 1) * ROWS_PER_STAGE));
        end
    end

    // A bubble leaves the sum register alone, so out_product keeps its last
    // value while out_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < LAT; k++) begin
                sum_q[k] <= '0;
            end
        end else if (adv) begin
            valid_q <= st_valid;
            for (int k = 0; k < LAT; k++) begin
                if (st_valid[k]) begin
                    sum_q[k] <= sum_d[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_array_multiplier_pipelined.sv
// ----------------------------------------------------------------------------
// Testbench for array_multiplier_pipelined. Six instances cover the
// (WIDTH, ROWS_PER_STAGE) sweep. Instance 0 is the default 8x8 with two rows
// per stage, and the directed tests use it. A queue-based scoreboard checks
// every product against a plain-arithmetic reference.
// ----------------------------------------------------------------------------
module tb_array_multiplier_pipelined;

    localparam int N = 6;
    localparam int WS [N] = '{8, 2, 4, 7, 16, 32};
    localparam int RS [N] = '{2, 1, 4, 3, 5, 32};

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
    } op_t;

    typedef struct packed {
        op_t         op;
        logic [63:0] p;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv    [N];
    logic        irdy  [N];
    logic [31:0] a_s   [N];
    logic [31:0] b_s   [N];
    logic        sg    [N];
    logic        ov    [N];
    logic        ordy  [N];
    logic [63:0] prod  [N];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        localparam int W = WS[gi];
        localparam int R = RS[gi];
        logic [2*W-1:0] p_w;
        logic           rdy_w;
        logic           ov_w;

        array_multiplier_pipelined #(
            .WIDTH          (W),
            .ROWS_PER_STAGE (R)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .in_valid    (iv[gi]),
            .in_ready    (rdy_w),
            .in_a        (a_s[gi][W-1:0]),
            .in_b        (b_s[gi][W-1:0]),
            .in_signed   (sg[gi]),
            .out_valid   (ov_w),
            .out_ready   (ordy[gi]),
            .out_product (p_w)
        );

        assign irdy[gi] = rdy_w;
        assign ov[gi]   = ov_w;
        assign prod[gi] = 64'(p_w);
    end

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    int          ordy_mode = 0;   // 0: always ready, 1: 1,0,0,1,0 pattern, 2: random
    bit          gaps = 1'b0;     // randomly drop in_valid while stimulus is pending
    bit          pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    op_t         stim_q [N][$];
    sb_t         exp_q  [N][$];
    bit          hold_f [N];
    logic [63:0] held   [N];
    int          pops   [N];

    function automatic int lat_of(int j);
        return (WS[j] + RS[j] - 1) / RS[j];
    endfunction

    function automatic logic [31:0] op_mask(int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    function automatic logic [63:0] prod_mask(int w);
        return (w >= 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // Reference: interpret operands as integers and multiply.
    function automatic logic [63:0] ref_mul(op_t op, int w);
        longint x;
        longint y;
        x = longint'(op.a & op_mask(w));
        y = longint'(op.b & op_mask(w));
        if (op.s && op.a[w-1]) x = x - (longint'(1) << w);
        if (op.s && op.b[w-1]) y = y - (longint'(1) << w);
        return 64'(x * y) & prod_mask(w);
    endfunction

    function automatic logic [31:0] rand_op(int w);
        int r;
        r = $urandom_range(0, 7);
        case (r)
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return op_mask(w);
            3:       return 32'd1 << (w - 1);
            default: return $urandom & op_mask(w);
        endcase
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int outstanding();
        int n;
        n = 0;
        for (int j = 0; j < N; j++) n += stim_q[j].size() + exp_q[j].size();
        return n;
    endfunction

    // One clock cycle, entered and left at the falling edge. Drives the next
    // inputs, predicts the handshakes of the coming rising edge, and checks
    // outputs and the stall rules.
    task automatic tick();
        sb_t e;
        op_t op;
        for (int j = 0; j < N; j++) begin
            if (hold_f[j]) begin
                check($sformatf("hold_valid%0d", j), 64'(ov[j]), 64'd1);
                check($sformatf("hold_prod%0d", j), prod[j], held[j]);
                hold_f[j] = 1'b0;
            end
            case (ordy_mode)
                0:       ordy[j] = 1'b1;
                1:       ordy[j] = pat[cyc % 5];
                default: ordy[j] = ($urandom_range(0, 3) != 0);
            endcase
            if (stim_q[j].size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
                iv[j]  = 1'b1;
                a_s[j] = stim_q[j][0].a;
                b_s[j] = stim_q[j][0].b;
                sg[j]  = stim_q[j][0].s;
            end else begin
                iv[j]  = 1'b0;
                a_s[j] = $urandom;
                b_s[j] = $urandom;
                sg[j]  = 1'($urandom_range(0, 1));
            end
        end
        #1;
        for (int j = 0; j < N; j++) begin
            if (ov[j] && !ordy[j]) begin
                check($sformatf("stall_ready%0d", j), 64'(irdy[j]), 64'd0);
                hold_f[j] = 1'b1;
                held[j]   = prod[j];
            end else begin
                check($sformatf("ready%0d", j), 64'(irdy[j]), 64'd1);
            end
            if (ov[j] && ordy[j]) begin
                check($sformatf("spurious%0d", j), 64'(exp_q[j].size() != 0), 64'd1);
                if (exp_q[j].size() != 0) begin
                    e = exp_q[j].pop_front();
                    check($sformatf("product%0d", j), prod[j], e.p);
                    pops[j]++;
                    $display("[TB] dut%0d W=%0d a=%0h b=%0h s=%0d product=%0h",
                             j, WS[j], e.op.a & op_mask(WS[j]), e.op.b & op_mask(WS[j]),
                             e.op.s, prod[j]);
                end
            end
            if (iv[j] && irdy[j]) begin
                op = stim_q[j].pop_front();
                exp_q[j].push_back('{op: op, p: ref_mul(op, WS[j])});
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(int budget);
        int n;
        n = 0;
        while (outstanding() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_outstanding", 64'(outstanding()), 64'd0);
    endtask

    task automatic push(int j, logic [31:0] a, logic [31:0] b, logic s);
        stim_q[j].push_back('{a: a & op_mask(WS[j]), b: b & op_mask(WS[j]), s: s});
    endtask

    initial begin
        logic [31:0] ca [4];
        logic [31:0] cb [4];
        logic        cs [4];
        logic [63:0] cx [4];
        logic [31:0] xs [4];
        int          idx;
        int          first_t;
        int          last_t;
        int          p0;

        ca = '{32'h80, 32'h80, 32'hFF, 32'hFF};
        cb = '{32'h80, 32'h7F, 32'hFF, 32'hFF};
        cs = '{1'b1, 1'b1, 1'b1, 1'b0};
        cx = '{64'h4000, 64'hC080, 64'h0001, 64'hFE01};

        rst = 1'b1;
        for (int j = 0; j < N; j++) begin
            iv[j] = 1'b0; ordy[j] = 1'b1; a_s[j] = '0; b_s[j] = '0; sg[j] = 1'b0;
            hold_f[j] = 1'b0; held[j] = '0; pops[j] = 0;
        end

        // Reset state
        @(posedge clk);
        @(negedge clk);
        for (int j = 0; j < N; j++) begin
            check($sformatf("rst_valid%0d", j), 64'(ov[j]), 64'd0);
            check($sformatf("rst_prod%0d", j), prod[j], 64'd0);
            check($sformatf("rst_ready%0d", j), 64'(irdy[j]), 64'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int j = 0; j < N; j++) check($sformatf("ready_after_rst%0d", j), 64'(irdy[j]), 64'd1);

        // Latency per instance, and all-ones unsigned (0xFF*0xFF on instance 0)
        for (int j = 0; j < N; j++) push(j, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        for (int e = 1; e <= 5; e++) begin
            tick();
            for (int j = 0; j < N; j++)
                check($sformatf("latency%0d_e%0d", j, e), 64'(ov[j]), 64'(e == lat_of(j)));
            if (e == 4) check("unsigned_basic", prod[0], 64'hFE01);
        end

        // Signed corners back to back on instance 0
        for (int k = 0; k < 4; k++) push(0, ca[k], cb[k], cs[k]);
        idx = 0; first_t = 0; last_t = 0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (ov[0]) begin
                if (idx < 4) check($sformatf("corner%0d", idx), prod[0], cx[idx]);
                if (idx == 0) first_t = t;
                last_t = t;
                idx++;
            end
        end
        check("corner_count", 64'(idx), 64'd4);
        check("corner_consecutive", 64'(last_t - first_t), 64'd3);

        // Backpressure: 10 random pairs with out_ready pattern 1,0,0,1,0
        ordy_mode = 1;
        p0 = pops[0];
        for (int k = 0; k < 10; k++) push(0, rand_op(8), rand_op(8), 1'($urandom_range(0, 1)));
        drain(200);
        check("bp_count", 64'(pops[0] - p0), 64'd10);
        ordy_mode = 0;

        // Reset in the middle of traffic
        for (int k = 0; k < 3; k++) push(0, rand_op(8), rand_op(8), 1'($urandom_range(0, 1)));
        repeat (5) tick();
        check("pre_rst_valid", 64'(ov[0]), 64'd1);
        rst = 1'b1;
        #1;
        check("midrst_valid", 64'(ov[0]), 64'd0);
        check("midrst_prod", prod[0], 64'd0);
        check("midrst_ready", 64'(irdy[0]), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("midrst_ready_hold", 64'(irdy[0]), 64'd0);
        rst = 1'b0;
        for (int j = 0; j < N; j++) begin
            stim_q[j].delete();
            exp_q[j].delete();
            hold_f[j] = 1'b0;
        end
        for (int t = 0; t < 6; t++) begin
            tick();
            check($sformatf("no_stale%0d", t), 64'(ov[0]), 64'd0);
        end
        p0 = pops[0];
        push(0, rand_op(8), rand_op(8), 1'($urandom_range(0, 1)));
        drain(20);
        check("post_rst_count", 64'(pops[0] - p0), 64'd1);

        // Zero / identity in both modes on every instance
        for (int j = 0; j < N; j++) begin
            xs = '{32'd0, 32'd1, op_mask(WS[j]), 32'd1 << (WS[j] - 1)};
            for (int s = 0; s < 2; s++) begin
                for (int k = 0; k < 4; k++) begin
                    push(j, 32'd0, xs[k], 1'(s));
                    push(j, 32'd1, xs[k], 1'(s));
                    push(j, xs[k], 32'd1, 1'(s));
                end
            end
        end
        drain(500);

        // Parameter sweep: 1000 random pairs per instance, random gaps and backpressure
        ordy_mode = 2;
        gaps = 1'b1;
        for (int j = 0; j < N; j++)
            for (int k = 0; k < 1000; k++)
                push(j, rand_op(WS[j]), rand_op(WS[j]), 1'($urandom_range(0, 1)));
        drain(20000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
